// File: rtl/sb_branch_sched.sv
// Clocked branch scheduler for the CUES SB stage: routes each accepted token to
// the switch or the matching memory, buffers DEPTH tokens and issues them in order.
module sb_branch_sched #(
  parameter int DW    = 64,
  parameter int DEPTH = 2,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lopen,
  input  logic          sp_disen,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_uni_opr,
  input  logic          in_pe_out,
  input  logic          in_lr,
  output logic          sw_valid,
  input  logic          sw_ready,
  output logic [DW-1:0] sw_data,
  output logic          sm_valid,
  input  logic          sm_ready,
  output logic [DW-1:0] sm_data,
  output logic [1:0]    sm_wen,
  output logic          busy,
  output logic [CW-1:0] sw_cnt,
  output logic [CW-1:0] sm_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_data  [DEPTH];
  logic          mem_to_sm [DEPTH];
  logic          mem_lr    [DEPTH];

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;

  logic not_empty;
  logic head_to_sm;
  logic head_lr;
  logic to_sm;
  logic push;
  logic sw_pop;
  logic sm_pop;
  logic pop;

  assign not_empty  = (count != '0);
  assign head_to_sm = mem_to_sm[rd_ptr];
  assign head_lr    = mem_lr[rd_ptr];
  assign to_sm      = in_uni_opr & ~in_pe_out & ~sp_disen;

  // Ready and valids come from registered state and lopen only, never from the sink readies.
  assign in_ready = lopen & (count != FULL_CNT);
  assign sw_valid = lopen & not_empty & ~head_to_sm;
  assign sm_valid = lopen & not_empty & head_to_sm;
  assign sw_data  = mem_data[rd_ptr];
  assign sm_data  = mem_data[rd_ptr];
  assign sm_wen   = sm_valid ? (head_lr ? 2'b10 : 2'b01) : 2'b00;
  assign busy     = not_empty;

  assign push   = in_valid & in_ready;
  assign sw_pop = sw_valid & sw_ready;
  assign sm_pop = sm_valid & sm_ready;
  assign pop    = sw_pop | sm_pop;

  // Route is resolved at accept time and stored alongside the payload.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr]  <= in_data;
      mem_to_sm[wr_ptr] <= to_sm;
      mem_lr[wr_ptr]    <= in_lr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Profiling counters wrap freely.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_cnt <= '0;
      sm_cnt <= '0;
    end else begin
      if (sw_pop) sw_cnt <= sw_cnt + CW'(1);
      if (sm_pop) sm_cnt <= sm_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_sb_branch_sched.sv
// Directed bench for sb_branch_sched: inputs change on the falling edge and
// outputs are compared 1ns later, well away from the rising edge.
module tb_sb_branch_sched;

  localparam int DW = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          lopen;
  logic          sp_disen;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_uni_opr;
  logic          in_pe_out;
  logic          in_lr;
  logic          sw_valid;
  logic          sw_ready;
  logic [DW-1:0] sw_data;
  logic          sm_valid;
  logic          sm_ready;
  logic [DW-1:0] sm_data;
  logic [1:0]    sm_wen;
  logic          busy;
  logic [CW-1:0] sw_cnt;
  logic [CW-1:0] sm_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sb_branch_sched #(.DW(DW), .DEPTH(2), .CW(CW)) dut (
    .clk(clk), .rst(rst), .lopen(lopen), .sp_disen(sp_disen),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_uni_opr(in_uni_opr), .in_pe_out(in_pe_out), .in_lr(in_lr),
    .sw_valid(sw_valid), .sw_ready(sw_ready), .sw_data(sw_data),
    .sm_valid(sm_valid), .sm_ready(sm_ready), .sm_data(sm_data),
    .sm_wen(sm_wen), .busy(busy), .sw_cnt(sw_cnt), .sm_cnt(sm_cnt)
  );

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: observed %h, expected %h", name, got, exp);
    end
  endtask

  task automatic set_token(input logic v, input logic [DW-1:0] d, input logic uni,
                           input logic pe, input logic lr);
    in_valid   = v;
    in_data    = d;
    in_uni_opr = uni;
    in_pe_out  = pe;
    in_lr      = lr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_token(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; lopen = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset in_ready", DW'(in_ready), DW'(1'b1));
    chk("reset sw_valid", DW'(sw_valid), DW'(1'b0));
    chk("reset sm_valid", DW'(sm_valid), DW'(1'b0));
    chk("reset sm_wen",   DW'(sm_wen),   DW'(2'b00));
    chk("reset busy",     DW'(busy),     DW'(1'b0));
    chk("reset sw_cnt",   DW'(sw_cnt),   DW'(0));
    chk("reset sm_cnt",   DW'(sm_cnt),   DW'(0));
  endtask

  task automatic test_routing();
    do_reset();
    sw_ready = 1'b1; sm_ready = 1'b1;
    set_token(1'b1, 16'hA0A0, 1'b1, 1'b0, 1'b1);
    #1 chk("route in_ready", DW'(in_ready), DW'(1'b1));
    @(negedge clk);
    set_token(1'b1, 16'hB0B0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("route A sm_valid", DW'(sm_valid), DW'(1'b1));
    chk("route A sw_valid", DW'(sw_valid), DW'(1'b0));
    chk("route A sm_data",  sm_data,       16'hA0A0);
    chk("route A sm_wen",   DW'(sm_wen),   DW'(2'b10));
    @(negedge clk);
    set_token(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("route B sw_valid", DW'(sw_valid), DW'(1'b1));
    chk("route B sm_valid", DW'(sm_valid), DW'(1'b0));
    chk("route B sw_data",  sw_data,       16'hB0B0);
    chk("route B sm_wen",   DW'(sm_wen),   DW'(2'b00));
    chk("route B sm_cnt",   DW'(sm_cnt),   DW'(1));
    @(negedge clk);
    #1;
    chk("route end busy",   DW'(busy),   DW'(1'b0));
    chk("route end sw_cnt", DW'(sw_cnt), DW'(1));
    chk("route end sm_cnt", DW'(sm_cnt), DW'(1));
  endtask

  task automatic test_sp_disen();
    do_reset();
    sw_ready = 1'b1; sm_ready = 1'b1;
    sp_disen = 1'b1;
    set_token(1'b1, 16'hC0C0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    sp_disen = 1'b0;
    set_token(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("spdis sw_valid", DW'(sw_valid), DW'(1'b1));
    chk("spdis sm_valid", DW'(sm_valid), DW'(1'b0));
    chk("spdis sw_data",  sw_data,       16'hC0C0);
    @(negedge clk);
    #1;
    chk("spdis busy",    DW'(busy),     DW'(1'b0));
    chk("spdis sm_valid after", DW'(sm_valid), DW'(1'b0));
    chk("spdis sw_cnt",  DW'(sw_cnt),   DW'(1));
    chk("spdis sm_cnt",  DW'(sm_cnt),   DW'(0));
  endtask

  task automatic test_hol_full();
    do_reset();
    sw_ready = 1'b1; sm_ready = 1'b0;
    set_token(1'b1, 16'hD0D0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    set_token(1'b1, 16'hE0E0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("hol one sm_valid", DW'(sm_valid), DW'(1'b1));
    chk("hol one sm_wen",   DW'(sm_wen),   DW'(2'b01));
    chk("hol one sw_valid", DW'(sw_valid), DW'(1'b0));
    chk("hol one in_ready", DW'(in_ready), DW'(1'b1));
    @(negedge clk);
    set_token(1'b1, 16'hF0F0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("hol full in_ready", DW'(in_ready), DW'(1'b0));
    chk("hol full sw_valid", DW'(sw_valid), DW'(1'b0));
    chk("hol full busy",     DW'(busy),     DW'(1'b1));
    @(negedge clk);
    sm_ready = 1'b1;
    #1;
    chk("hol pop in_ready", DW'(in_ready), DW'(1'b0));
    chk("hol pop sm_valid", DW'(sm_valid), DW'(1'b1));
    chk("hol pop sm_data",  sm_data,       16'hD0D0);
    @(negedge clk);
    #1;
    chk("hol E sw_valid", DW'(sw_valid), DW'(1'b1));
    chk("hol E sm_valid", DW'(sm_valid), DW'(1'b0));
    chk("hol E sw_data",  sw_data,       16'hE0E0);
    chk("hol E in_ready", DW'(in_ready), DW'(1'b1));
    @(negedge clk);
    set_token(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("hol F sw_valid", DW'(sw_valid), DW'(1'b1));
    chk("hol F sw_data",  sw_data,       16'hF0F0);
    @(negedge clk);
    #1;
    chk("hol end busy",   DW'(busy),   DW'(1'b0));
    chk("hol end sw_cnt", DW'(sw_cnt), DW'(2));
    chk("hol end sm_cnt", DW'(sm_cnt), DW'(1));
  endtask

  task automatic test_lopen_freeze();
    do_reset();
    sw_ready = 1'b0; sm_ready = 1'b0;
    set_token(1'b1, 16'h1111, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    set_token(1'b1, 16'h2222, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    set_token(1'b1, 16'h3333, 1'b0, 1'b0, 1'b0);
    lopen = 1'b0; sw_ready = 1'b1; sm_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("freeze sw_valid", DW'(sw_valid), DW'(1'b0));
      chk("freeze sm_valid", DW'(sm_valid), DW'(1'b0));
      chk("freeze in_ready", DW'(in_ready), DW'(1'b0));
      chk("freeze busy",     DW'(busy),     DW'(1'b1));
      @(negedge clk);
    end
    #1;
    chk("freeze sw_cnt", DW'(sw_cnt), DW'(0));
    chk("freeze sm_cnt", DW'(sm_cnt), DW'(0));
    lopen = 1'b1;
    set_token(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("resume first sw_valid", DW'(sw_valid), DW'(1'b1));
    chk("resume first sw_data",  sw_data,       16'h1111);
    @(negedge clk);
    #1;
    chk("resume second sm_valid", DW'(sm_valid), DW'(1'b1));
    chk("resume second sm_data",  sm_data,       16'h2222);
    chk("resume second sm_wen",   DW'(sm_wen),   DW'(2'b10));
    @(negedge clk);
    #1;
    chk("resume busy",   DW'(busy),   DW'(1'b0));
    chk("resume sw_cnt", DW'(sw_cnt), DW'(1));
    chk("resume sm_cnt", DW'(sm_cnt), DW'(1));
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    sw_ready = 1'b1; sm_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      set_token(1'b1, DW'(16'h0100 + i), 1'b0, 1'b0, 1'b0);
      #1;
      chk("wrap in_ready", DW'(in_ready), DW'(1'b1));
      if (i > 0) chk("wrap sw_data", sw_data, DW'(16'h0100 + i - 1));
      @(negedge clk);
    end
    set_token(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1 chk("wrap last sw_data", sw_data, 16'h0110);
    @(negedge clk);
    #1;
    chk("wrap sw_cnt", DW'(sw_cnt), DW'(1));
    chk("wrap busy",   DW'(busy),   DW'(1'b0));
    sw_ready = 1'b0;
    set_token(1'b1, 16'h5A5A, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    set_token(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1 chk("midrst busy before", DW'(busy), DW'(1'b1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; sw_ready = 1'b1;
    #1;
    chk("midrst busy",   DW'(busy),   DW'(1'b0));
    chk("midrst sw_cnt", DW'(sw_cnt), DW'(0));
    for (int i = 0; i < 3; i++) begin
      chk("midrst sw_valid", DW'(sw_valid), DW'(1'b0));
      @(negedge clk);
      #1;
    end
    chk("midrst sw_cnt hold", DW'(sw_cnt), DW'(0));
  endtask

  initial begin
    rst = 1'b1; lopen = 1'b1; sp_disen = 1'b0;
    sw_ready = 1'b0; sm_ready = 1'b0;
    set_token(1'b0, '0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_routing();
    test_sp_disen();
    test_hol_full();
    test_lopen_freeze();
    test_wrap_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
